viterbi_frame_sequencer: RTL and testbench
==========================================

# viterbi_frame_sequencer

Frame-level controller for the Viterbi decoder pipeline (serial-to-vector, branch metric, path decider, path memory, min-cost, restore-bits). It admits coded bits from the demapper, counts trellis steps, stalls the input at each 32-step traceback block, sequences the min-cost search, path-memory read and bit restoration, and hands each decoded 32-bit word downstream with a valid/ready handshake. The whole chain thereby runs one frame of N words per `start`, instead of free-running.

## Interface
- `TB_DEPTH`, 32: trellis steps per traceback block; must equal the width of the decoded-bits word.
- `WDOG_MAX`, 1023: watchdog limit in cycles, used only when the watchdog is compiled in.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame request; honoured only in IDLE.
- `rate` in 4: 802.11a RATE code, latched on `start`.
- `n_words` in 8: frame length in 32-bit words, latched on `start`; 0 is illegal.
- `bit_in` in 1: coded bit from upstream.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: the sequencer accepts a bit this cycle.
- `sv_bit` out 1: registered copy of the accepted bit, sent to serial-to-vector.
- `sv_en` out 1: clock enable for serial-to-vector; high in a cycle where a bit was accepted in the previous cycle.
- `chain_run` out 1: level run/reset for serial-to-vector, path decider and path memory; high from frame start until frame end.
- `rate_o` out 4: latched rate, sent to the chain.
- `sv_done` in 1: one pulse per completed trellis step.
- `mc_done` in 1: min-cost search complete.
- `mem_re` out 1: one-cycle path-memory read strobe.
- `rb_done` in 1: restore-bits complete.
- `rb_bits` in 32: decoded word.
- `word_out` out 32: held decoded word.
- `word_valid` out 1: `word_out` is valid.
- `word_ready` in 1: downstream accepts the word.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last word is accepted.
- `err` out 1: sticky error flag; cleared on the next accepted `start`.

## Operation
- Legal rate codes: 1101, 1111, 0101, 0111, 1001, 1011, 0001, 0011.
- Error on `start`: an illegal rate or `n_words`=0 sets `err`, and the block stays in IDLE.
- States:
  - IDLE -> ACQ on a legal `start`. Latch `rate` and `n_words`, clear the step and word counters, clear `err`, raise `chain_run` and `busy`.
  - ACQ:
    - `bit_ready`=1.
    - Each `sv_done` increments the 5-bit step counter.
    - When the counter reaches TB_DEPTH-1 and `sv_done` pulses: the counter wraps to 0, `bit_ready` drops in the same cycle, and the state goes to WMC.
  - WMC: `bit_ready`=0. On `mc_done`, pulse `mem_re` for one cycle and go to WRB.
  - WRB: on `rb_done`, load `word_out` from `rb_bits`, set `word_valid`, go to OUT.
  - OUT: hold `word_out` and `word_valid` until `word_ready`. On acceptance, increment the word counter.
    - If words remain: go to ACQ.
    - Otherwise: pulse `frame_done`, drop `chain_run` and `busy`, go to IDLE.
- `bit_valid` low in ACQ: this is a stall, not an error; the step counter holds.
- `sv_done` outside ACQ: ignored, no count.
- `start` while `busy`: ignored, no error.
- `mc_done` and `rb_done` outside their wait state: ignored.

## Timing
- Reset values: every output 0, state IDLE, counters 0.
- Reset is asynchronous: asserting `reset` mid-frame forces the reset values immediately, including `chain_run`=0.
- Legal `start` at edge T: `busy`, `chain_run` and `bit_ready` are 1 from T+1.
- Bit path: a bit accepted at edge T appears on `sv_bit` with `sv_en`=1 during T+1 (one-cycle register).
- `mem_re`: asserted for exactly the cycle after the edge that samples `mc_done`.
- `word_valid`: rises the cycle after the edge that samples `rb_done`.
- Word acceptance: the word is accepted on the edge where `word_valid` and `word_ready` are both 1. When more words remain, `bit_ready` returns high in the next cycle.
- Frame end: `frame_done` is high for the single cycle after the last acceptance, and `busy` is 0 in that same cycle.
- Back-to-back frames: a `start` in the cycle `frame_done` is high is accepted.

## Configuration
- `VITERBI_SEQ_WDOG_EN` defined: a 10-bit watchdog counts cycles in WMC and WRB and clears on every state change.
  - At WDOG_MAX: set `err`, drop `chain_run`, `busy` and `word_valid`, go to IDLE. No `frame_done`.
- Undefined: no watchdog; WMC and WRB wait indefinitely.

## Test plan
- Legal frame: `rate`=1101, `n_words`=2, continuous bits, `sv_done` every 2 cycles, `mc_done`/`rb_done` 5 cycles after their trigger, `word_ready`=1.
  - Expect exactly 2 `mem_re` pulses and 2 words equal to the `rb_bits` stimulus.
  - Expect `bit_ready` low from the 32nd `sv_done` until the word is accepted.
  - Expect `frame_done` once.
- Illegal start: `rate`=0000 -> `err`=1, `busy` stays 0. Then a legal `start` -> `err`=0 and `busy`=1 the next cycle.
- Back-pressure: `word_ready` held 0 for 20 cycles.
  - Expect `word_out` stable and `word_valid`=1 throughout, `bit_ready`=0, and no extra steps counted.
- Mid-frame reset: `reset` low after the 17th `sv_done` -> all outputs 0 immediately. A new frame then counts from 0.
- Watchdog, with `VITERBI_SEQ_WDOG_EN`: withhold `mc_done` -> `err`=1 and IDLE after 1023 cycles in WMC. Without the macro -> still in WMC after 2000 cycles.

Source files
------------

// File: rtl/viterbi_frame_sequencer_if.sv
// Handshake and data bundle between the Viterbi frame sequencer and its neighbours:
// the demapper, the decoder chain stages and the downstream word consumer.
// The sequencer connects through the slave modport; the environment drives it through master.
interface viterbi_frame_sequencer_if #(
    parameter int W = 32
);
    logic         start;
    logic [3:0]   rate;
    logic [7:0]   n_words;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic         sv_bit;
    logic         sv_en;
    logic         chain_run;
    logic [3:0]   rate_o;
    logic         sv_done;
    logic         mc_done;
    logic         mem_re;
    logic         rb_done;
    logic [W-1:0] rb_bits;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         busy;
    logic         frame_done;
    logic         err;

    modport slave (
        input  start, rate, n_words, bit_in, bit_valid, sv_done, mc_done,
               rb_done, rb_bits, word_ready,
        output bit_ready, sv_bit, sv_en, chain_run, rate_o, mem_re,
               word_out, word_valid, busy, frame_done, err
    );

    modport master (
        output start, rate, n_words, bit_in, bit_valid, sv_done, mc_done,
               rb_done, rb_bits, word_ready,
        input  bit_ready, sv_bit, sv_en, chain_run, rate_o, mem_re,
               word_out, word_valid, busy, frame_done, err
    );
endinterface

// File: rtl/viterbi_frame_sequencer.sv
// Frame-level controller for the Viterbi decoder chain.
// The block admits coded bits and counts trellis steps. At the end of each traceback block
// it stalls the input and then sequences three steps: the min-cost search, the path-memory
// read and bit restoration. It hands each decoded word downstream over a valid/ready
// handshake, and runs n_words words per start.
// Optional build macro VITERBI_SEQ_WDOG_EN adds a watchdog on the WMC/WRB waits.
module viterbi_frame_sequencer #(
    parameter int TB_DEPTH = 32
`ifdef VITERBI_SEQ_WDOG_EN
    , parameter int WDOG_MAX = 1023
`endif
) (
    input logic                     clk,
    input logic                     reset,
    viterbi_frame_sequencer_if.slave bus
);
    localparam int STEP_W = $clog2(TB_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ACQ, S_WMC, S_WRB, S_OUT} state_t;

    state_t                r_state, w_state_nxt;
    logic [STEP_W-1:0]     r_step;
    logic [7:0]            r_word;
    logic [7:0]            r_nwords;
    logic [3:0]            r_rate;
    logic                  r_err;
    logic                  r_sv_bit;
    logic                  r_sv_en;
    logic                  r_mem_re;
    logic                  r_word_valid;
    logic                  r_frame_done;
    logic [TB_DEPTH-1:0]   r_word_out;

    logic w_rate_ok, w_start_ok, w_start_bad, w_step_last;
    logic w_bit_ready, w_accept, w_step_evt, w_mc_evt, w_rb_evt;
    logic w_word_acc, w_last_word, w_wdog_hit;

    // Legal 802.11a RATE codes; every other code is rejected at start
    always_comb begin
        w_rate_ok = 1'b0;
        case (bus.rate)
            4'b1101, 4'b1111, 4'b0101, 4'b0111,
            4'b1001, 4'b1011, 4'b0001, 4'b0011: w_rate_ok = 1'b1;
            default:                            w_rate_ok = 1'b0;
        endcase
    end

    assign w_start_ok  = (r_state == S_IDLE) && bus.start && w_rate_ok && (bus.n_words != 8'd0);
    assign w_start_bad = (r_state == S_IDLE) && bus.start && !(w_rate_ok && (bus.n_words != 8'd0));
    assign w_step_last = (r_step == STEP_W'(TB_DEPTH - 1));
    assign w_accept    = w_bit_ready && bus.bit_valid;
    assign w_step_evt  = (r_state == S_ACQ) && bus.sv_done;
    assign w_mc_evt    = (r_state == S_WMC) && bus.mc_done && !w_wdog_hit;
    assign w_rb_evt    = (r_state == S_WRB) && bus.rb_done && !w_wdog_hit;
    assign w_word_acc  = (r_state == S_OUT) && r_word_valid && bus.word_ready;
    assign w_last_word = ((r_word + 8'd1) == r_nwords);

`ifdef VITERBI_SEQ_WDOG_EN
    logic [9:0] r_wdog;

    assign w_wdog_hit = ((r_state == S_WMC) || (r_state == S_WRB)) && (r_wdog == 10'(WDOG_MAX));

    // Watchdog counts cycles spent waiting on the chain and restarts on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wdog <= '0;
        else if (w_state_nxt != r_state)
            r_wdog <= '0;
        else if (((r_state == S_WMC) || (r_state == S_WRB)) && (r_wdog != 10'(WDOG_MAX)))
            r_wdog <= r_wdog + 10'd1;
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and input-ready; bit_ready drops combinationally on the block-closing step
    always_comb begin
        w_state_nxt = r_state;
        w_bit_ready = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_ACQ;
            S_ACQ: begin
                w_bit_ready = 1'b1;
                if (bus.sv_done && w_step_last) begin
                    w_bit_ready = 1'b0;
                    w_state_nxt = S_WMC;
                end
            end
            S_WMC:  if (bus.mc_done) w_state_nxt = S_WRB;
            S_WRB:  if (bus.rb_done) w_state_nxt = S_OUT;
            S_OUT:  if (r_word_valid && bus.word_ready)
                        w_state_nxt = w_last_word ? S_IDLE : S_ACQ;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_wdog_hit) w_state_nxt = S_IDLE;
    end

    // Datapath: frame parameters, counters, bit register, strobes and the output word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step       <= '0;
            r_word       <= '0;
            r_nwords     <= '0;
            r_rate       <= '0;
            r_err        <= 1'b0;
            r_sv_bit     <= 1'b0;
            r_sv_en      <= 1'b0;
            r_mem_re     <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_word_out   <= '0;
        end else begin
            r_sv_en      <= w_accept;
            r_mem_re     <= w_mc_evt;
            r_frame_done <= w_word_acc && w_last_word;
            if (w_accept) r_sv_bit <= bus.bit_in;

            if (w_start_ok) begin
                r_rate   <= bus.rate;
                r_nwords <= bus.n_words;
                r_step   <= '0;
                r_word   <= '0;
                r_err    <= 1'b0;
            end else if (w_start_bad || w_wdog_hit) begin
                r_err <= 1'b1;
            end

            if (w_step_evt) r_step <= w_step_last ? '0 : r_step + STEP_W'(1);

            if (w_rb_evt) begin
                r_word_out   <= bus.rb_bits;
                r_word_valid <= 1'b1;
            end
            if (w_word_acc) begin
                r_word_valid <= 1'b0;
                r_word       <= r_word + 8'd1;
            end
            if (w_wdog_hit) r_word_valid <= 1'b0;
        end
    end

    assign bus.bit_ready  = w_bit_ready;
    assign bus.sv_bit     = r_sv_bit;
    assign bus.sv_en      = r_sv_en;
    assign bus.chain_run  = (r_state != S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rate_o     = r_rate;
    assign bus.mem_re     = r_mem_re;
    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Self-checking bench for viterbi_frame_sequencer: start-vector table, full frames with a
// word scoreboard, back-pressure, back-to-back frames, mid-frame reset and the WMC wait.
module tb_viterbi_frame_sequencer;
    logic clk;
    logic reset;
    viterbi_frame_sequencer_if bus();

    viterbi_frame_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mem_cnt = 0;
    int fd_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    typedef struct {
        logic [3:0] rate;
        logic [7:0] nw;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and strobe counters, sampled away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_re) mem_cnt++;
            if (bus.frame_done) fd_cnt++;
            if (bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL word_pop: unexpected word %0h", bus.word_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word_out_acc", {32'd0, bus.word_out}, {32'd0, exp_w});
                end
            end
        end
    end

    task automatic do_start(input logic [3:0] r, input logic [7:0] nw);
        cycle();
        bus.start = 1'b1; bus.rate = r; bus.n_words = nw;
        cycle();
        bus.start = 1'b0;
        chk("start_busy", {bus.busy, bus.chain_run, bus.bit_ready}, 3'b111);
    endtask

    // n sv_done pulses, every second cycle, bits streaming continuously
    task automatic do_steps(input int n, input bit ends);
        bus.bit_valid = 1'b1;
        for (int s = 0; s < n; s++) begin
            bus.bit_in  = s[0];
            bus.sv_done = 1'b1;
            #1 chk("bit_ready_acq", bus.bit_ready, (ends && s == n - 1) ? 1'b0 : 1'b1);
            cycle();
            bus.sv_done = 1'b0;
            if (s == 0) chk("sv_path", {bus.sv_en, bus.sv_bit}, 2'b10);
            cycle();
        end
    endtask

    // Block tail: min-cost, path read, restore, word handoff
    task automatic do_block(input logic [31:0] v, input int bp, input bit last, input bit b2b);
        chk("sv_en_stalled", bus.sv_en, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bit_ready_wmc", bus.bit_ready, 1'b0);
            cycle();
        end
        bus.mc_done = 1'b1;
        cycle();
        bus.mc_done = 1'b0;
        chk("mem_re_hi", bus.mem_re, 1'b1);
        cycle();
        chk("mem_re_lo", bus.mem_re, 1'b0);
        repeat (3) cycle();
        bus.rb_bits = v; bus.rb_done = 1'b1;
        exp_q.push_back(v);
        cycle();
        bus.rb_done = 1'b0; bus.rb_bits = ~v;
        chk("word_valid_rise", {bus.word_valid, 32'd0, bus.word_out}, {1'b1, 32'd0, v});
        for (int k = 0; k < bp; k++) begin
            chk("bp_hold", {bus.word_valid, bus.bit_ready, 31'd0, bus.word_out}, {1'b1, 1'b0, 31'd0, v});
            bus.sv_done = k[0];
            cycle();
        end
        bus.sv_done = 1'b0;
        bus.word_ready = 1'b1;
        cycle();
        bus.word_ready = 1'b0;
        if (last) begin
            chk("frame_end", {bus.frame_done, bus.busy, bus.chain_run}, 3'b100);
            if (b2b) begin
                bus.start = 1'b1; bus.rate = 4'b0011; bus.n_words = 8'd1;
            end
            cycle();
            bus.start = 1'b0;
            chk("frame_done_1cyc", bus.frame_done, 1'b0);
            if (b2b) chk("b2b_busy", {bus.busy, bus.bit_ready, bus.err}, 3'b110);
        end else begin
            chk("next_block", {bus.bit_ready, bus.word_valid}, 2'b10);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {bus.busy, bus.chain_run, bus.bit_ready, bus.sv_en, bus.sv_bit, bus.mem_re,
                 bus.word_valid, bus.frame_done, bus.err, bus.rate_o, bus.word_out}, '0);
    endtask

    initial begin
        tbl[0] = '{4'b0000, 8'd1,   1'b1, 1'b0};
        tbl[1] = '{4'b1101, 8'd0,   1'b1, 1'b0};
        tbl[2] = '{4'b1101, 8'd1,   1'b0, 1'b1};
        tbl[3] = '{4'b0010, 8'd3,   1'b1, 1'b0};
        tbl[4] = '{4'b0011, 8'd5,   1'b0, 1'b1};
        tbl[5] = '{4'b1000, 8'd2,   1'b1, 1'b0};
        tbl[6] = '{4'b1111, 8'd255, 1'b0, 1'b1};
        tbl[7] = '{4'b1110, 8'd0,   1'b1, 1'b0};

        reset = 1'b0;
        bus.start = 1'b0; bus.rate = '0; bus.n_words = '0;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.sv_done = 1'b0;
        bus.mc_done = 1'b0; bus.rb_done = 1'b0; bus.rb_bits = '0; bus.word_ready = 1'b0;
        #12 chk_zero("reset_state");
        cycle();
        reset = 1'b1;

        // start-vector table: error flag, busy and latched rate
        for (int i = 0; i < 8; i++) begin
            cycle();
            bus.start = 1'b1; bus.rate = tbl[i].rate; bus.n_words = tbl[i].nw;
            cycle();
            bus.start = 1'b0;
            chk("tbl_err_busy", {bus.err, bus.busy}, {tbl[i].exp_err, tbl[i].exp_busy});
            if (tbl[i].exp_busy) begin
                chk("tbl_rate_o", bus.rate_o, tbl[i].rate);
                bus.start = 1'b1; bus.rate = 4'b0000;
                cycle();
                bus.start = 1'b0;
                chk("start_while_busy", {bus.err, bus.busy}, 2'b01);
                reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        // two-word frame, then back-to-back one-word frame
        mem_cnt = 0; fd_cnt = 0;
        cycle();
        do_start(4'b1101, 8'd2);
        do_steps(32, 1'b1);
        do_block(32'hA5C3_0F01, 0, 1'b0, 1'b0);
        do_steps(32, 1'b1);
        do_block(32'h1234_5678, 20, 1'b1, 1'b1);
        do_steps(32, 1'b1);
        do_block(32'hDEAD_BEEF, 2, 1'b1, 1'b0);
        repeat (2) cycle();
        chk("mem_re_count", mem_cnt, 3);
        chk("frame_done_count", fd_cnt, 2);
        chk("queue_empty", exp_q.size(), 0);

        // mid-frame reset, then a fresh frame counts from zero
        do_start(4'b1101, 8'd3);
        do_steps(17, 1'b0);
        reset = 1'b0;
        #1 chk_zero("midframe_reset");
        cycle();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.sv_done = 1'b1; bus.mc_done = 1'b1; bus.rb_done = 1'b1;
            cycle();
            bus.sv_done = 1'b0; bus.mc_done = 1'b0; bus.rb_done = 1'b0;
            cycle();
        end
        chk("idle_ignore", {bus.busy, bus.mem_re, bus.word_valid}, 3'b000);
        do_start(4'b0101, 8'd1);
        do_steps(32, 1'b1);
        do_block(32'h0F0F_F0F0, 0, 1'b1, 1'b0);

        // withheld mc_done
        do_start(4'b1111, 8'd1);
        do_steps(32, 1'b1);
        repeat (2000) cycle();
`ifdef VITERBI_SEQ_WDOG_EN
        chk("wdog_abort", {bus.err, bus.busy, bus.chain_run, bus.frame_done}, 4'b1000);
`else
        chk("wmc_wait", {bus.err, bus.busy, bus.chain_run, bus.bit_ready}, 4'b0110);
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
